// File: rtl/id_ex.sv
// ID/EX pipeline register with valid/ready handshake on both sides.
// Optional macro ID_EX_SKID_EN adds a second (skid) entry so id_ready is
// driven purely from registered state; without it the block is a single
// entry whose id_ready looks through to ex_ready.
module id_ex #(
   parameter logic [31:0] NOP_INS = 32'h00000013,
   parameter int unsigned OH_W    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     id_ins,
   input  logic [31:0]     id_ins_addr,
   input  logic [31:0]     id_op1,
   input  logic [31:0]     id_op2,
   input  logic [4:0]      id_rd_addr,
   input  logic            id_rd_wen,
   input  logic [OH_W-1:0] id_oh,
   input  logic            id_valid,
   output logic            id_ready,
   output logic [31:0]     ex_ins,
   output logic [31:0]     ex_ins_addr,
   output logic [31:0]     ex_op1,
   output logic [31:0]     ex_op2,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_rd_wen,
   output logic [OH_W-1:0] ex_oh,
   output logic            ex_valid,
   input  logic            ex_ready,
   input  logic            flush
);

   localparam int unsigned PW = 32 * 4 + 5 + 1 + OH_W;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StMain  = 2'd1,
      StSkid  = 2'd2
   } state_e;

   state_e          r_state, w_state_nxt;
   logic [PW-1:0]   w_id_pld;
   logic [PW-1:0]   r_main, w_main_nxt;
   logic            w_in_xfer, w_out_xfer;

   logic [31:0]     w_m_ins, w_m_addr, w_m_op1, w_m_op2;
   logic [4:0]      w_m_rd;
   logic            w_m_wen;
   logic [OH_W-1:0] w_m_oh;

   assign w_id_pld = {id_ins, id_ins_addr, id_op1, id_op2, id_rd_addr, id_rd_wen, id_oh};
   assign {w_m_ins, w_m_addr, w_m_op1, w_m_op2, w_m_rd, w_m_wen, w_m_oh} = r_main;

   assign ex_valid   = (r_state != StEmpty);
   assign w_in_xfer  = id_valid && id_ready;
   assign w_out_xfer = ex_valid && ex_ready;

`ifdef ID_EX_SKID_EN
   logic [PW-1:0] r_skid, w_skid_nxt;

   // Registered-only ready: the skid entry absorbs the one beat in flight.
   assign id_ready = (r_state != StSkid);

   // Skid entry register; only written when main is stalled and input arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_skid <= '0;
      else        r_skid <= w_skid_nxt;
   end
`else
   // Single entry: accept when empty or when the held entry leaves this cycle.
   assign id_ready = !ex_valid || ex_ready;
`endif

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StEmpty;
      else        r_state <= w_state_nxt;
   end

   // Main entry register; ex_* always reflect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_main <= '0;
      else        r_main <= w_main_nxt;
   end

   // Next-state and register-load decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
`ifdef ID_EX_SKID_EN
      w_skid_nxt  = r_skid;
`endif
      case (r_state)
         StEmpty: begin
            if (w_in_xfer) begin
               w_main_nxt  = w_id_pld;
               w_state_nxt = StMain;
            end
         end
         StMain: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_nxt = w_id_pld;
`ifdef ID_EX_SKID_EN
            end else if (w_in_xfer) begin
               w_skid_nxt  = w_id_pld;
               w_state_nxt = StSkid;
`endif
            end else if (w_out_xfer) begin
               w_state_nxt = StEmpty;
            end
         end
`ifdef ID_EX_SKID_EN
         StSkid: begin
            if (w_out_xfer) begin
               w_main_nxt  = r_skid;
               w_state_nxt = StMain;
            end
         end
`endif
         default: w_state_nxt = StEmpty;
      endcase
      // Flush drops everything; an output transfer this cycle still counts downstream.
      if (flush) w_state_nxt = StEmpty;
   end

   // Output mux: bubble payload whenever nothing valid is held.
   always_comb begin
      ex_ins      = NOP_INS;
      ex_ins_addr = '0;
      ex_op1      = '0;
      ex_op2      = '0;
      ex_rd_addr  = '0;
      ex_rd_wen   = 1'b0;
      ex_oh       = '0;
      if (ex_valid) begin
         ex_ins      = w_m_ins;
         ex_ins_addr = w_m_addr;
         ex_op1      = w_m_op1;
         ex_op2      = w_m_op2;
         ex_rd_addr  = w_m_rd;
         ex_rd_wen   = w_m_wen;
         ex_oh       = w_m_oh;
      end
   end

endmodule

// File: tb/tb_id_ex.sv
// Testbench for id_ex: queue-based scoreboard with an occupancy model,
// a random vector table plus directed corner sequences.
module tb_id_ex;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam int          OHW = 5;
   localparam int          PW  = 32 * 4 + 5 + 1 + OHW;
`ifdef ID_EX_SKID_EN
   localparam int          DEPTH = 2;
`else
   localparam int          DEPTH = 1;
`endif
   localparam logic [PW-1:0] BUBBLE = {NOP, {(PW - 32){1'b0}}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid = 1'b0;
   logic ex_ready = 1'b0;
   logic flush = 1'b0;
   logic [PW-1:0] tb_pld = '0;

   logic [31:0]    id_ins, id_ins_addr, id_op1, id_op2;
   logic [4:0]     id_rd_addr;
   logic           id_rd_wen;
   logic [OHW-1:0] id_oh;
   logic           id_ready;
   logic [31:0]    ex_ins, ex_ins_addr, ex_op1, ex_op2;
   logic [4:0]     ex_rd_addr;
   logic           ex_rd_wen;
   logic [OHW-1:0] ex_oh;
   logic           ex_valid;
   logic [PW-1:0]  ex_pld;

   assign {id_ins, id_ins_addr, id_op1, id_op2, id_rd_addr, id_rd_wen, id_oh} = tb_pld;
   assign ex_pld = {ex_ins, ex_ins_addr, ex_op1, ex_op2, ex_rd_addr, ex_rd_wen, ex_oh};

   id_ex #(
      .NOP_INS (NOP),
      .OH_W    (OHW)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_ins      (id_ins),
      .id_ins_addr (id_ins_addr),
      .id_op1      (id_op1),
      .id_op2      (id_op2),
      .id_rd_addr  (id_rd_addr),
      .id_rd_wen   (id_rd_wen),
      .id_oh       (id_oh),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .ex_ins      (ex_ins),
      .ex_ins_addr (ex_ins_addr),
      .ex_op1      (ex_op1),
      .ex_op2      (ex_op2),
      .ex_rd_addr  (ex_rd_addr),
      .ex_rd_wen   (ex_rd_wen),
      .ex_oh       (ex_oh),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] sb_q[$];
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic          v;
      logic          r;
      logic          f;
      logic [PW-1:0] p;
   } vec_t;
   vec_t tbl[48];

   function automatic logic [PW-1:0] mk_pld(input logic [31:0] addr);
      logic [31:0]    ins, op1, op2;
      logic [4:0]     rd;
      logic           wen;
      logic [OHW-1:0] oh;
      ins = $urandom();
      op1 = $urandom();
      op2 = $urandom();
      rd  = 5'($urandom());
      wen = 1'($urandom());
      oh  = OHW'($urandom());
      return {ins, addr, op1, op2, rd, wen, oh};
   endfunction

   function automatic logic mdl_ready(input logic rdy);
      if (DEPTH == 2) return sb_q.size() < 2;
      return (sb_q.size() == 0) || rdy;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, check against the model, then advance the model at the edge.
   task automatic step(input logic v, input logic r, input logic f, input logic [PW-1:0] p);
      logic rdy, in_x, out_x;
      @(negedge clk);
      id_valid = v;
      ex_ready = r;
      flush    = f;
      tb_pld   = p;
      #1;
      rdy = mdl_ready(r);
      chk1("ex_valid", ex_valid, sb_q.size() > 0);
      chk1("id_ready", id_ready, rdy);
      chkw("ex_payload", ex_pld, (sb_q.size() > 0) ? sb_q[0] : BUBBLE);
      in_x  = v && rdy;
      out_x = (sb_q.size() > 0) && r;
      @(posedge clk);
      if (out_x) void'(sb_q.pop_front());
      if (f) sb_q.delete();
      else if (in_x) sb_q.push_back(p);
   endtask

   initial begin
      logic [PW-1:0] pa, pb, pc;

      // Reset state while rst_n is held low.
      #1;
      chk1("rst_ex_valid", ex_valid, 1'b0);
      chk1("rst_id_ready", id_ready, 1'b1);
      chk32("rst_ex_ins", ex_ins, NOP);
      chk1("rst_ex_rd_wen", ex_rd_wen, 1'b0);
      chk32("rst_ex_op1", ex_op1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming: back-to-back beats, one cycle latency, no gaps.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, mk_pld(32'(k * 4)));
         #1;
         chk1("stream_valid", ex_valid, 1'b1);
         chk32("stream_addr", ex_ins_addr, 32'(k * 4));
      end
      step(1'b0, 1'b1, 1'b0, '0);

      // Backpressure: A then B with ex_ready low; A must be held stable.
      pa = mk_pld(32'h100);
      pb = mk_pld(32'h104);
      step(1'b1, 1'b0, 1'b0, pa);
      step(1'b1, 1'b0, 1'b0, pb);
      #1;
      chk1("bp_id_ready", id_ready, 1'b0);
      chk32("bp_hold_a", ex_ins_addr, 32'h100);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);

      // Flush while full, with C arriving in the flush cycle.
      pa = mk_pld(32'h200);
      pb = mk_pld(32'h204);
      pc = mk_pld(32'h208);
      pc[PW-1-32*4-5] = 1'b1;  // C carries rd_wen=1 so a leak would show
      step(1'b1, 1'b0, 1'b0, pa);
      step(1'b1, 1'b0, 1'b0, pb);
      step(1'b1, 1'b0, 1'b1, pc);
      #1;
      chk1("flush_valid", ex_valid, 1'b0);
      chk1("flush_rd_wen", ex_rd_wen, 1'b0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);

      // Simultaneous in/out from a single held entry.
      pa = mk_pld(32'h300);
      pb = mk_pld(32'h304);
      step(1'b1, 1'b0, 1'b0, pa);
      step(1'b1, 1'b1, 1'b0, pb);
      #1;
      chk1("simul_valid", ex_valid, 1'b1);
      chk32("simul_addr", ex_ins_addr, 32'h304);
      step(1'b0, 1'b1, 1'b0, '0);

      // Flush concurrent with an output transfer.
      step(1'b1, 1'b0, 1'b0, mk_pld(32'h380));
      step(1'b1, 1'b1, 1'b1, mk_pld(32'h384));
      step(1'b0, 1'b1, 1'b0, '0);

`ifndef ID_EX_SKID_EN
      // Single-entry build: id_ready follows ex_ready combinationally.
      step(1'b1, 1'b0, 1'b0, mk_pld(32'h3C0));
      @(negedge clk);
      id_valid = 1'b0;
      ex_ready = 1'b0;
      #1;
      chk1("cfg_ready_lo", id_ready, 1'b0);
      ex_ready = 1'b1;
      #1;
      chk1("cfg_ready_hi", id_ready, 1'b1);
      ex_ready = 1'b0;
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
`endif

      // Random vector table.
      for (int i = 0; i < 48; i++) begin
         tbl[i].v = ($urandom_range(3) != 0);
         tbl[i].r = ($urandom_range(2) != 0);
         tbl[i].f = ($urandom_range(15) == 0);
         tbl[i].p = mk_pld(32'(32'h400 + i * 4));
      end
      for (int i = 0; i < 48; i++) step(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].p);

      // Asynchronous reset with both entries occupied.
      step(1'b1, 1'b0, 1'b0, mk_pld(32'h500));
      step(1'b1, 1'b0, 1'b0, mk_pld(32'h504));
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_ex_valid", ex_valid, 1'b0);
      chk32("arst_ex_ins", ex_ins, NOP);
      chk1("arst_id_ready", id_ready, 1'b1);
      sb_q.delete();
      id_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      pa = mk_pld(32'h600);
      step(1'b1, 1'b0, 1'b0, pa);
      #1;
      chk32("post_rst_accept", ex_ins_addr, 32'h600);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
